pass_scheduler: RTL and testbench

Top-level pass sequencer for the Eyeriss accelerator. It steps a layer through its output-channel groups (m) and input-channel groups (c). For each pass it launches the ifmap and filter GLB loaders, waits for both, runs the PE array, and after the last c-group of each m-group launches psum write-back. It sits between the AXI-lite configuration registers and the loader/PE-array controllers, and only exchanges start/done pulses with them.

---
 rtl/pass_scheduler.sv | 158 +++++++++++++++
 tb/tb_pass_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_scheduler.sv
`default_nettype none
// ============================================================================
// pass_scheduler: steps a layer through m/c pass groups, sequencing loaders,
// PE-array runs and psum write-back via start/done pulse handshakes.
// Revision: 1.0
// ============================================================================
module pass_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_num_m_pass,
  input  logic [CNT_W-1:0] i_num_c_pass,
  output logic             o_ifmap_load_start,
  output logic             o_filt_load_start,
  input  logic             i_ifmap_load_done,
  input  logic             i_filt_load_done,
  output logic             o_run_start,
  input  logic             i_run_done,
  output logic             o_psum_wb_start,
  input  logic             i_psum_wb_done,
  output logic             o_psum_acc,
  output logic [CNT_W-1:0] o_m_idx,
  output logic [CNT_W-1:0] o_c_idx,
  output logic             o_busy,
  output logic             o_layer_done
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_LOAD = 3'd1;
  localparam logic [2:0] c_ST_RUN  = 3'd2;
  localparam logic [2:0] c_ST_WB   = 3'd3;
  localparam logic [2:0] c_ST_NEXT = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_entry;
  logic [CNT_W-1:0] r_num_m;
  logic [CNT_W-1:0] r_num_c;
  logic [CNT_W-1:0] r_m_idx;
  logic [CNT_W-1:0] r_c_idx;
  logic             r_ifmap_seen;
  logic             r_filt_seen;

  logic w_ifmap_done_ok;
  logic w_filt_done_ok;
  logic w_run_done_ok;
  logic w_wb_done_ok;
  logic w_load_complete;
  logic w_c_last;
  logic w_m_last;
  logic w_zero_cnt;
  logic w_abort_ok;

  // r_entry marks the first cycle of a state: that is when the start pulse is
  // out, so a done arriving in that same cycle cannot belong to it.
  assign w_ifmap_done_ok = (r_state == c_ST_LOAD) && !r_entry && i_ifmap_load_done;
  assign w_filt_done_ok  = (r_state == c_ST_LOAD) && !r_entry && i_filt_load_done;
  assign w_run_done_ok   = (r_state == c_ST_RUN)  && !r_entry && i_run_done;
  assign w_wb_done_ok    = (r_state == c_ST_WB)   && !r_entry && i_psum_wb_done;

  assign w_load_complete = (r_ifmap_seen | w_ifmap_done_ok) & (r_filt_seen | w_filt_done_ok);
  assign w_c_last        = (r_c_idx == (r_num_c - c_ONE));
  assign w_m_last        = (r_m_idx == (r_num_m - c_ONE));
  assign w_zero_cnt      = (i_num_m_pass == '0) || (i_num_c_pass == '0);
  assign w_abort_ok      = i_abort && (r_state != c_ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= c_ST_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_entry <= (w_next_state != r_state);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_abort_ok) begin
      w_next_state = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (i_start) w_next_state = w_zero_cnt ? c_ST_DONE : c_ST_LOAD;
        c_ST_LOAD: if (w_load_complete) w_next_state = c_ST_RUN;
        c_ST_RUN:  if (w_run_done_ok) w_next_state = w_c_last ? c_ST_WB : c_ST_NEXT;
        c_ST_WB:   if (w_wb_done_ok) w_next_state = c_ST_NEXT;
        c_ST_NEXT: w_next_state = (w_c_last && w_m_last) ? c_ST_DONE : c_ST_LOAD;
        c_ST_DONE: w_next_state = c_ST_IDLE;
        default:   w_next_state = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_num_m      <= '0;
      r_num_c      <= '0;
      r_m_idx      <= '0;
      r_c_idx      <= '0;
      r_ifmap_seen <= 1'b0;
      r_filt_seen  <= 1'b0;
    end else if (w_abort_ok) begin
      r_m_idx      <= '0;
      r_c_idx      <= '0;
      r_ifmap_seen <= 1'b0;
      r_filt_seen  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_start) begin
            r_num_m <= i_num_m_pass;
            r_num_c <= i_num_c_pass;
            r_m_idx <= '0;
            r_c_idx <= '0;
          end
        end
        c_ST_LOAD: begin
          if (w_next_state != c_ST_LOAD) begin
            r_ifmap_seen <= 1'b0;
            r_filt_seen  <= 1'b0;
          end else begin
            if (w_ifmap_done_ok) r_ifmap_seen <= 1'b1;
            if (w_filt_done_ok)  r_filt_seen  <= 1'b1;
          end
        end
        c_ST_NEXT: begin
          if (!w_c_last) begin
            r_c_idx <= r_c_idx + c_ONE;
          end else if (!w_m_last) begin
            r_c_idx <= '0;
            r_m_idx <= r_m_idx + c_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ifmap_load_start = (r_state == c_ST_LOAD) && r_entry;
    o_filt_load_start  = (r_state == c_ST_LOAD) && r_entry;
    o_run_start        = (r_state == c_ST_RUN)  && r_entry;
    o_psum_wb_start    = (r_state == c_ST_WB)   && r_entry;
    o_psum_acc         = (r_c_idx != '0);
    o_m_idx            = r_m_idx;
    o_c_idx            = r_c_idx;
    o_busy             = (r_state != c_ST_IDLE);
    o_layer_done       = (r_state == c_ST_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_pass_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pass_scheduler: directed bench with a pass-list model and per-cycle compare.
// Revision: 1.0
// ============================================================================
module tb_pass_scheduler;

  localparam int CNT_W = 8;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_WB = 3, P_NEXT = 4, P_DONE = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_m;
  logic [CNT_W-1:0] num_c;
  logic             ifmap_start, filt_start, run_start, wb_start;
  logic             r_ifd, r_fd, r_rd, r_wd, man_rd;
  wire              run_done = r_rd | man_rd;
  logic             psum_acc, busy, layer_done;
  logic [CNT_W-1:0] m_idx, c_idx;

  pass_scheduler #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_num_m_pass(num_m), .i_num_c_pass(num_c),
    .o_ifmap_load_start(ifmap_start), .o_filt_load_start(filt_start),
    .i_ifmap_load_done(r_ifd), .i_filt_load_done(r_fd),
    .o_run_start(run_start), .i_run_done(run_done),
    .o_psum_wb_start(wb_start), .i_psum_wb_done(r_wd),
    .o_psum_acc(psum_acc), .o_m_idx(m_idx), .o_c_idx(c_idx),
    .o_busy(busy), .o_layer_done(layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: pass index p walks m-major, c-minor
  int ph = P_IDLE, age = 0, p = 0, lm = 0, lc = 0, em = 0, ec = 0;
  bit seen_i = 0, seen_f = 0;

  initial begin
    int nph;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        ph = P_IDLE; age = 0; p = 0; lm = 0; lc = 0; em = 0; ec = 0;
        seen_i = 0; seen_f = 0;
      end else begin
        nph = ph;
        if (ph != P_IDLE && abort) begin
          nph = P_IDLE; p = 0; em = 0; ec = 0; seen_i = 0; seen_f = 0;
        end else begin
          case (ph)
            P_IDLE: if (start) begin
              lm = int'(num_m); lc = int'(num_c); p = 0; em = 0; ec = 0;
              nph = (lm == 0 || lc == 0) ? P_DONE : P_LOAD;
            end
            P_LOAD: begin
              if (age > 0 && r_ifd) seen_i = 1;
              if (age > 0 && r_fd)  seen_f = 1;
              if (seen_i && seen_f) begin nph = P_RUN; seen_i = 0; seen_f = 0; end
            end
            P_RUN:  if (age > 0 && run_done) nph = (ec == lc - 1) ? P_WB : P_NEXT;
            P_WB:   if (age > 0 && r_wd) nph = P_NEXT;
            P_NEXT: if (p + 1 < lm * lc) begin
              p++; em = p / lc; ec = p % lc; nph = P_LOAD;
            end else nph = P_DONE;
            default: nph = P_IDLE;
          endcase
        end
        age = (nph != ph) ? 0 : age + 1;
        ph  = nph;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy",        busy,        32'(ph != P_IDLE));
      chk("layer_done",  layer_done,  32'(ph == P_DONE));
      chk("ifmap_start", ifmap_start, 32'(ph == P_LOAD && age == 0));
      chk("filt_start",  filt_start,  32'(ph == P_LOAD && age == 0));
      chk("run_start",   run_start,   32'(ph == P_RUN && age == 0));
      chk("wb_start",    wb_start,    32'(ph == P_WB && age == 0));
      chk("psum_acc",    psum_acc,    32'(ec != 0));
      chk("m_idx",       m_idx,       32'(em));
      chk("c_idx",       c_idx,       32'(ec));
    end
  end

  // ---------------- responder: returns each done a programmable delay after its start
  int dly_if = 3, dly_f = 3, dly_run = 3, dly_wb = 3;
  bit coinc_f = 0;
  int cnt_if = 0, cnt_f = 0, cnt_run = 0, cnt_wb = 0;
  int n_load = 0, n_run = 0, n_wb = 0, n_done = 0;
  int last_if_cyc = 0, last_f_cyc = 0, last_run_cyc = 0, done_cyc = 0;
  int log_m[64], log_c[64], log_acc[64], wb_c[16];

  initial begin
    r_ifd = 0; r_fd = 0; r_rd = 0; r_wd = 0;
    forever begin
      @(posedge clk); #1;
      r_ifd = 0; r_fd = 0; r_rd = 0; r_wd = 0;
      if (cnt_if  > 0) begin cnt_if--;  if (cnt_if  == 0) begin r_ifd = 1; last_if_cyc = cyc; end end
      if (cnt_f   > 0) begin cnt_f--;   if (cnt_f   == 0) begin r_fd  = 1; last_f_cyc  = cyc; end end
      if (cnt_run > 0) begin cnt_run--; if (cnt_run == 0) r_rd = 1; end
      if (cnt_wb  > 0) begin cnt_wb--;  if (cnt_wb  == 0) r_wd = 1; end
      if (ifmap_start) begin
        cnt_if = dly_if;
        if (dly_if == 0) begin r_ifd = 1; last_if_cyc = cyc; end
        if (n_load < 64) begin
          log_m[n_load] = int'(m_idx); log_c[n_load] = int'(c_idx); log_acc[n_load] = int'(psum_acc);
        end
        n_load++;
      end
      if (filt_start) begin
        cnt_f = dly_f;
        if (dly_f == 0 || coinc_f) begin r_fd = 1; last_f_cyc = cyc; end
      end
      if (run_start) begin cnt_run = dly_run; last_run_cyc = cyc; n_run++; if (dly_run == 0) r_rd = 1; end
      if (wb_start) begin
        cnt_wb = dly_wb; if (dly_wb == 0) r_wd = 1;
        if (n_wb < 16) wb_c[n_wb] = int'(c_idx);
        n_wb++;
      end
      if (layer_done) begin n_done++; done_cyc = cyc; end
    end
  end

  // ---------------- stimulus
  task automatic run_layer(input int m, input int c, input bit noisy, output int lat);
    int s, d0;
    @(negedge clk);
    num_m = CNT_W'(m); num_c = CNT_W'(c); start = 1; s = cyc; d0 = n_done; lat = -1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = 0;
      num_m = CNT_W'(m); num_c = CNT_W'(c);
      if (n_done != d0) begin lat = done_cyc - s; break; end
      if (noisy && (i % 7) == 3) begin start = 1; num_m = 8'd5; num_c = 8'd5; end
    end
    start = 0;
    if (lat < 0) chk("layer_timeout", 1, 0);
  endtask

  task automatic wait_for_cond(input int which, input string name);
    bit hit = 0;
    for (int i = 0; i < 800 && !hit; i++) begin
      @(negedge clk);
      start = 0;
      if (which == 0) hit = run_start && m_idx == 8'd1 && c_idx == 8'd1;
      else            hit = wb_start;
    end
    if (!hit) chk(name, 0, 1);
  endtask

  int exp_m[6]   = '{0, 0, 0, 1, 1, 1};
  int exp_c[6]   = '{0, 1, 2, 0, 1, 2};
  int exp_acc[6] = '{0, 1, 1, 0, 1, 1};

  initial begin
    int lat, b_load, b_run, b_wb, b_done;
    rst_n = 0; start = 0; abort = 0; man_rd = 0; num_m = 0; num_c = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_m_idx", m_idx, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // m=1, c=1: done 14 cycles after start, one of each pulse
    b_load = n_load; b_run = n_run; b_wb = n_wb;
    run_layer(1, 1, 0, lat);
    chk("m1c1_latency", lat, 14);
    chk("m1c1_loads", n_load - b_load, 1);
    chk("m1c1_runs", n_run - b_run, 1);
    chk("m1c1_wbs", n_wb - b_wb, 1);
    chk("m1c1_acc", log_acc[b_load], 0);
    @(negedge clk);
    chk("m1c1_busy_fall", busy, 0);

    // m=2, c=3 with unequal delays
    dly_if = 2; dly_f = 4; dly_run = 3; dly_wb = 2;
    b_load = n_load; b_run = n_run; b_wb = n_wb;
    run_layer(2, 3, 0, lat);
    chk("m2c3_loads", n_load - b_load, 6);
    chk("m2c3_runs", n_run - b_run, 6);
    chk("m2c3_wbs", n_wb - b_wb, 2);
    for (int i = 0; i < 6; i++) begin
      chk("m2c3_seq_m", log_m[b_load + i], exp_m[i]);
      chk("m2c3_seq_c", log_c[b_load + i], exp_c[i]);
      chk("m2c3_seq_acc", log_acc[b_load + i], exp_acc[i]);
    end
    chk("m2c3_wb0_c", wb_c[b_wb], 2);
    chk("m2c3_wb1_c", wb_c[b_wb + 1], 2);

    // filt done 5 cycles before ifmap done
    dly_if = 6; dly_f = 1;
    run_layer(1, 1, 0, lat);
    chk("order_if_last", last_run_cyc - last_if_cyc, 1);
    chk("order_f_early", last_if_cyc - last_f_cyc, 5);
    // both dones in the same cycle
    dly_if = 4; dly_f = 4;
    run_layer(1, 1, 0, lat);
    chk("order_same", last_run_cyc - last_if_cyc, 1);
    // filt done coincident with its start is ignored; real one follows 3 later
    dly_if = 2; dly_f = 3; coinc_f = 1;
    run_layer(1, 1, 0, lat);
    chk("coinc_wait", last_run_cyc - last_f_cyc, 1);
    coinc_f = 0; dly_if = 3; dly_f = 3;

    // zero count
    b_load = n_load; b_run = n_run;
    run_layer(0, 4, 0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_loads", n_load - b_load, 0);
    chk("zero_runs", n_run - b_run, 0);
    @(negedge clk);
    chk("zero_idle", busy, 0);

    // abort during RUN at (1,1)
    dly_if = 2; dly_f = 2; dly_run = 12; dly_wb = 2;
    b_done = n_done;
    @(negedge clk);
    num_m = 8'd2; num_c = 8'd3; start = 1;
    wait_for_cond(0, "abort_reach_timeout");
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_m_idx", m_idx, 0);
    chk("abort_c_idx", c_idx, 0);
    repeat (3) @(negedge clk);
    man_rd = 1;
    @(negedge clk);
    man_rd = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done - b_done, 0);
    chk("abort_still_idle", busy, 0);
    dly_run = 2;
    b_load = n_load;
    run_layer(1, 2, 0, lat);
    chk("restart_m", log_m[b_load], 0);
    chk("restart_c", log_c[b_load], 0);
    chk("restart_loads", n_load - b_load, 2);

    // start pulses while busy are ignored
    b_load = n_load; b_wb = n_wb;
    run_layer(2, 2, 1, lat);
    chk("busy_start_loads", n_load - b_load, 4);
    chk("busy_start_wbs", n_wb - b_wb, 2);

    // reset during WB
    dly_wb = 6;
    b_done = n_done;
    @(negedge clk);
    num_m = 8'd1; num_c = 8'd1; start = 1;
    wait_for_cond(1, "wb_reach_timeout");
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_wb_busy", busy, 0);
    chk("rst_wb_wbstart", wb_start, 0);
    chk("rst_wb_done", layer_done, 0);
    rst_n = 1;
    repeat (15) @(negedge clk);
    chk("rst_wb_no_done", n_done - b_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
